// File: rtl/addr_map_pkg.sv
// -----------------------------------------------------------------------------
// addr_map_pkg
// Shared definitions for the table-driven SNES address mapper:
//   - cfg_sel field encodings used by the MCU table-write port
//   - bit positions inside the per-window flags field
//   - a15 qualification mode encodings of the range field
//   - unlock/relock FSM state enumeration
//   - packed window configuration record
// No ports (package).
// -----------------------------------------------------------------------------
package addr_map_pkg;

   // cfg_sel encodings
   localparam logic [1:0] SEL_RANGE = 2'd0;
   localparam logic [1:0] SEL_MASK  = 2'd1;
   localparam logic [1:0] SEL_DEST  = 2'd2;
   localparam logic [1:0] SEL_FLAGS = 2'd3;

   // flags field bit positions
   localparam int FLAG_EN    = 0;
   localparam int FLAG_WR    = 1;
   localparam int FLAG_SAVE  = 2;
   localparam int FLAG_LOROM = 3;

   // range[17:16]: A15 qualification
   localparam logic [1:0] A15_ANY   = 2'b00;
   localparam logic [1:0] A15_LOW   = 2'b01;
   localparam logic [1:0] A15_HIGH  = 2'b10;
   localparam logic [1:0] A15_NEVER = 2'b11;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_UNLOCKED = 2'd1,
      ST_RELOCK   = 2'd2
   } map_state_t;

   // One mapping window. range: [7:0] bank_lo, [15:8] bank_hi, [17:16] a15 mode.
   typedef struct packed {
      logic [17:0] range;
      logic [23:0] mask;
      logic [23:0] dest;
      logic [3:0]  flags;
   } win_cfg_t;

endpackage

// File: rtl/addr_map_win.sv
// -----------------------------------------------------------------------------
// addr_map_win
// Combinational match and address translation for a single mapping window.
// Ports:
//   win_cfg    in   window record (range, mask, dest, flags)
//   snes_addr  in   24-bit SNES address being decoded
//   hit        out  window is enabled and the address falls inside it
//   xlat_addr  out  dest | (offset & mask), valid when hit is set
// -----------------------------------------------------------------------------
module addr_map_win
   import addr_map_pkg::*;
(
   input  win_cfg_t    win_cfg,
   input  logic [23:0] snes_addr,
   output logic        hit,
   output logic [23:0] xlat_addr
);

   logic [7:0]  bank;
   logic [7:0]  bank_lo;
   logic [7:0]  bank_hi;
   logic [7:0]  bank_rel;
   logic        a15_ok;
   logic [23:0] offset;

   assign bank    = snes_addr[23:16];
   assign bank_lo = win_cfg.range[7:0];
   assign bank_hi = win_cfg.range[15:8];

   always_comb begin
      a15_ok = 1'b0;
      case (win_cfg.range[17:16])
         A15_ANY:  a15_ok = 1'b1;
         A15_LOW:  a15_ok = ~snes_addr[15];
         A15_HIGH: a15_ok = snes_addr[15];
         default:  a15_ok = 1'b0;   // A15_NEVER parks a window without clearing enable
      endcase
   end

   // Bank distance wraps in 8 bits; only meaningful when the window hits.
   assign bank_rel = bank - bank_lo;

   // LoROM packs 32 KiB per bank, so A15 is squeezed out of the offset.
   assign offset = win_cfg.flags[FLAG_LOROM] ? {1'b0, bank_rel, snes_addr[14:0]}
                                             : {bank_rel, snes_addr[15:0]};

   assign hit = win_cfg.flags[FLAG_EN] && (bank >= bank_lo) && (bank <= bank_hi) && a15_ok;

   assign xlat_addr = win_cfg.dest | (offset & win_cfg.mask);

endmodule

// File: rtl/addr_map_ctrl.sv
// -----------------------------------------------------------------------------
// addr_map_ctrl
// Table-driven SNES address mapper with MCU-programmable windows (lowest index
// wins), a patch-bank override while unlocked, and a timed unlock/relock FSM.
// The decode result is registered one CLK after each SNES address strobe.
//
// Optional build macro: ADDR_MAP_HITCNT_EN
//   defined   -> per-window 16-bit saturating hit counters, read on cfg_rdata,
//                cleared by a flags write to that window
//   undefined -> no counters, cfg_rdata tied to 0
//
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   SNES_ADDR        SNES address, valid while SNES_ADDR_STB is high
//   SNES_ADDR_STB    one pulse per SNES bus cycle
//   SNES_ROMSEL      ROMSEL (active low)
//   cfg_we/win/sel   MCU table write: strobe, window index, field select
//   cfg_wdata        field data
//   cfg_rdata        hit counter of cfg_win (0 when counters are not built)
//   unlock_req       unlock pulse from snescmd logic
//   ROM_ADDR         translated address
//   ROM_HIT          decode maps to SRAM
//   IS_SAVERAM       matched window is save RAM
//   IS_WRITABLE      writes permitted
//   WIN_IDX          matched window index
//   DEC_VALID        one-cycle pulse with each new decode result
//   map_unlocked     FSM is not LOCKED (registered)
// -----------------------------------------------------------------------------
module addr_map_ctrl
   import addr_map_pkg::*;
#(
   parameter int          NUM_WIN    = 4,
   parameter logic [23:0] RET_VEC    = 24'h002A5A,
   parameter int          RELOCK_CNT = 16,
   localparam int         WIN_W      = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [23:0]      SNES_ADDR,
   input  logic             SNES_ADDR_STB,
   input  logic             SNES_ROMSEL,
   input  logic             cfg_we,
   input  logic [WIN_W-1:0] cfg_win,
   input  logic [1:0]       cfg_sel,
   input  logic [23:0]      cfg_wdata,
   output logic [23:0]      cfg_rdata,
   input  logic             unlock_req,
   output logic [23:0]      ROM_ADDR,
   output logic             ROM_HIT,
   output logic             IS_SAVERAM,
   output logic             IS_WRITABLE,
   output logic [2:0]       WIN_IDX,
   output logic             DEC_VALID,
   output logic             map_unlocked
);

   // ---------------------------------------------------------------------
   // Reset: assertion takes effect immediately, release is retimed to CLK
   // so every flop leaves reset on the same edge.
   // ---------------------------------------------------------------------
   logic [1:0] rst_sync_reg;
   logic       rst_int_n;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rst_sync_reg <= 2'b00;
      else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end

   assign rst_int_n = rst_sync_reg[1];

   // ---------------------------------------------------------------------
   // Window table and per-window match logic
   // ---------------------------------------------------------------------
   logic [NUM_WIN-1:0] win_hit;
   logic [NUM_WIN-1:0] win_wr;
   logic [NUM_WIN-1:0] win_save;
   logic [23:0]        win_xlat [NUM_WIN];

   generate
      for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
         win_cfg_t cfg_reg;

         always_ff @(posedge CLK or negedge rst_int_n) begin
            if (!rst_int_n) begin
               cfg_reg <= '0;
            end else if (cfg_we && (cfg_win == WIN_W'(gi))) begin
               case (cfg_sel)
                  SEL_RANGE: cfg_reg.range <= cfg_wdata[17:0];
                  SEL_MASK:  cfg_reg.mask  <= cfg_wdata;
                  SEL_DEST:  cfg_reg.dest  <= cfg_wdata;
                  default:   cfg_reg.flags <= cfg_wdata[3:0];
               endcase
            end
         end

         addr_map_win u_win (
            .win_cfg   (cfg_reg),
            .snes_addr (SNES_ADDR),
            .hit       (win_hit[gi]),
            .xlat_addr (win_xlat[gi])
         );

         assign win_wr[gi]   = cfg_reg.flags[FLAG_WR];
         assign win_save[gi] = cfg_reg.flags[FLAG_SAVE];
      end
   endgenerate

   // Priority encode: scan from the top so the lowest hitting index is the
   // last assignment and therefore wins.
   logic        win_found;
   logic [2:0]  win_idx;
   logic [23:0] win_addr;
   logic        win_wr_sel;
   logic        win_save_sel;

   always_comb begin
      win_found    = 1'b0;
      win_idx      = 3'd0;
      win_addr     = '0;
      win_wr_sel   = 1'b0;
      win_save_sel = 1'b0;
      for (int i = NUM_WIN - 1; i >= 0; i--) begin
         if (win_hit[i]) begin
            win_found    = 1'b1;
            win_idx      = 3'(i);
            win_addr     = win_xlat[i];
            win_wr_sel   = win_wr[i];
            win_save_sel = win_save[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Unlock / relock FSM
   // ---------------------------------------------------------------------
   map_state_t state_reg, state_next;
   logic [7:0] relock_cnt_reg, relock_cnt_next;
   logic       map_unlocked_reg;
   logic       ret_fetch;

   assign ret_fetch = SNES_ADDR_STB && (SNES_ADDR == RET_VEC);

   always_comb begin
      state_next      = state_reg;
      relock_cnt_next = relock_cnt_reg;
      case (state_reg)
         ST_LOCKED: begin
            if (unlock_req) state_next = ST_UNLOCKED;
         end
         ST_UNLOCKED: begin
            if (ret_fetch) begin
               state_next      = ST_RELOCK;
               relock_cnt_next = 8'(RELOCK_CNT);
            end
         end
         ST_RELOCK: begin
            // A fresh unlock during the grace period cancels the relock.
            if (unlock_req) begin
               state_next = ST_UNLOCKED;
            end else if (SNES_ADDR_STB) begin
               relock_cnt_next = relock_cnt_reg - 8'd1;
               if (relock_cnt_reg <= 8'd1) begin
                  state_next      = ST_LOCKED;
                  relock_cnt_next = 8'd0;
               end
            end
         end
         default: begin
            state_next      = ST_LOCKED;
            relock_cnt_next = 8'd0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_reg        <= ST_LOCKED;
         relock_cnt_reg   <= 8'd0;
         map_unlocked_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         relock_cnt_reg   <= relock_cnt_next;
         map_unlocked_reg <= (state_next != ST_LOCKED);
      end
   end

   // ---------------------------------------------------------------------
   // Decode (uses the FSM state before this cycle's transition)
   // ---------------------------------------------------------------------
   logic        is_unlocked;
   logic        patch_hit;
   logic        romsel_wr;
   logic [23:0] dec_addr_next;
   logic        dec_hit_next;
   logic        dec_save_next;
   logic        dec_wr_next;
   logic [2:0]  dec_idx_next;

   assign is_unlocked = (state_reg != ST_LOCKED);
   assign patch_hit   = is_unlocked && (SNES_ADDR[23:20] == 4'hF);
   assign romsel_wr   = is_unlocked && !SNES_ROMSEL;

   always_comb begin
      dec_addr_next = '0;
      dec_hit_next  = 1'b0;
      dec_save_next = 1'b0;
      dec_wr_next   = romsel_wr;
      dec_idx_next  = 3'd0;
      if (patch_hit) begin
         dec_addr_next = SNES_ADDR;
         dec_hit_next  = 1'b1;
         dec_wr_next   = 1'b1;
      end else if (win_found) begin
         dec_addr_next = win_addr;
         dec_hit_next  = 1'b1;
         dec_save_next = win_save_sel;
         dec_wr_next   = win_wr_sel | romsel_wr;
         dec_idx_next  = win_idx;
      end
   end

   logic [23:0] rom_addr_reg;
   logic        rom_hit_reg;
   logic        is_saveram_reg;
   logic        is_writable_reg;
   logic [2:0]  win_idx_reg;
   logic        dec_valid_reg;

   always_ff @(posedge CLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         rom_addr_reg    <= '0;
         rom_hit_reg     <= 1'b0;
         is_saveram_reg  <= 1'b0;
         is_writable_reg <= 1'b0;
         win_idx_reg     <= 3'd0;
         dec_valid_reg   <= 1'b0;
      end else begin
         dec_valid_reg <= SNES_ADDR_STB;
         if (SNES_ADDR_STB) begin
            rom_addr_reg    <= dec_addr_next;
            rom_hit_reg     <= dec_hit_next;
            is_saveram_reg  <= dec_save_next;
            is_writable_reg <= dec_wr_next;
            win_idx_reg     <= dec_idx_next;
         end
      end
   end

   assign ROM_ADDR     = rom_addr_reg;
   assign ROM_HIT      = rom_hit_reg;
   assign IS_SAVERAM   = is_saveram_reg;
   assign IS_WRITABLE  = is_writable_reg;
   assign WIN_IDX      = win_idx_reg;
   assign DEC_VALID    = dec_valid_reg;
   assign map_unlocked = map_unlocked_reg;

   // ---------------------------------------------------------------------
   // Optional per-window hit counters
   // ---------------------------------------------------------------------
`ifdef ADDR_MAP_HITCNT_EN
   logic [15:0] hitcnt [NUM_WIN];

   generate
      for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_hitcnt
         logic [15:0] cnt_reg;
         logic        cnt_clr;
         logic        cnt_inc;

         // Patch decodes override the table and are not attributed to a window.
         assign cnt_clr = cfg_we && (cfg_sel == SEL_FLAGS) && (cfg_win == WIN_W'(gi));
         assign cnt_inc = SNES_ADDR_STB && !patch_hit && win_found && (win_idx == 3'(gi));

         always_ff @(posedge CLK or negedge rst_int_n) begin
            if (!rst_int_n) begin
               cnt_reg <= 16'd0;
            end else if (cnt_clr) begin
               cnt_reg <= 16'd0;
            end else if (cnt_inc && (cnt_reg != 16'hFFFF)) begin
               cnt_reg <= cnt_reg + 16'd1;
            end
         end

         assign hitcnt[gi] = cnt_reg;
      end
   endgenerate

   always_comb begin
      cfg_rdata = '0;
      for (int i = 0; i < NUM_WIN; i++) begin
         if (cfg_win == WIN_W'(i)) cfg_rdata = {8'h00, hitcnt[i]};
      end
   end
`else
   assign cfg_rdata = '0;
`endif

endmodule

// File: tb/tb_addr_map_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addr_map_ctrl
// Self-checking bench for addr_map_ctrl: directed scenarios followed by a
// random mix of table writes, unlock pulses, idle cycles and strobes, all
// compared against a behavioural reference model of the mapping rules.
// Build with ADDR_MAP_HITCNT_EN to check the hit counters; otherwise
// cfg_rdata is expected to read 0.
// -----------------------------------------------------------------------------
module tb_addr_map_ctrl;

   localparam int          NW    = 4;
   localparam int          WW    = 2;
   localparam logic [23:0] RET   = 24'h002A5A;
   localparam int          RCNT  = 16;

   logic          CLK;
   logic          RST_N;
   logic [23:0]   SNES_ADDR;
   logic          SNES_ADDR_STB;
   logic          SNES_ROMSEL;
   logic          cfg_we;
   logic [WW-1:0] cfg_win;
   logic [1:0]    cfg_sel;
   logic [23:0]   cfg_wdata;
   logic [23:0]   cfg_rdata;
   logic          unlock_req;
   logic [23:0]   ROM_ADDR;
   logic          ROM_HIT;
   logic          IS_SAVERAM;
   logic          IS_WRITABLE;
   logic [2:0]    WIN_IDX;
   logic          DEC_VALID;
   logic          map_unlocked;

   addr_map_ctrl #(
      .NUM_WIN    (NW),
      .RET_VEC    (RET),
      .RELOCK_CNT (RCNT)
   ) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .SNES_ADDR     (SNES_ADDR),
      .SNES_ADDR_STB (SNES_ADDR_STB),
      .SNES_ROMSEL   (SNES_ROMSEL),
      .cfg_we        (cfg_we),
      .cfg_win       (cfg_win),
      .cfg_sel       (cfg_sel),
      .cfg_wdata     (cfg_wdata),
      .cfg_rdata     (cfg_rdata),
      .unlock_req    (unlock_req),
      .ROM_ADDR      (ROM_ADDR),
      .ROM_HIT       (ROM_HIT),
      .IS_SAVERAM    (IS_SAVERAM),
      .IS_WRITABLE   (IS_WRITABLE),
      .WIN_IDX       (WIN_IDX),
      .DEC_VALID     (DEC_VALID),
      .map_unlocked  (map_unlocked)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [23:0] m_tab [NW][4];   // [window][field]: range, mask, dest, flags
   int          m_hits [NW];
   bit          m_unlocked;      // not LOCKED
   bit          m_relocking;     // in the grace period after handler exit
   int          m_left;          // strobes left before relock
   logic [23:0] e_addr;
   logic        e_hit, e_save, e_wr;
   logic [2:0]  e_idx;
   int          cur_win;

   function automatic void model_reset();
      for (int w = 0; w < NW; w++) begin
         for (int f = 0; f < 4; f++) m_tab[w][f] = '0;
         m_hits[w] = 0;
      end
      m_unlocked  = 0;
      m_relocking = 0;
      m_left      = 0;
      e_addr = '0; e_hit = 0; e_save = 0; e_wr = 0; e_idx = '0;
   endfunction

   // Computes the expected decode of address a; winner = -1 when no window wins.
   function automatic void model_decode(input logic [23:0] a, input bit romsel, output int winner);
      int          bank, lo, hi, off;
      logic [23:0] r, f;
      bit          mode_ok;
      winner = -1;
      if (m_unlocked && a[23:20] == 4'hF) begin
         e_addr = a; e_hit = 1; e_wr = 1; e_save = 0; e_idx = 0;
         return;
      end
      bank = int'(a[23:16]);
      for (int w = 0; w < NW; w++) begin
         if (winner < 0) begin
            r  = m_tab[w][0];
            f  = m_tab[w][3];
            lo = int'(r[7:0]);
            hi = int'(r[15:8]);
            case (r[17:16])
               2'b00:   mode_ok = 1;
               2'b01:   mode_ok = (a[15] == 1'b0);
               2'b10:   mode_ok = (a[15] == 1'b1);
               default: mode_ok = 0;
            endcase
            if (f[0] && bank >= lo && bank <= hi && mode_ok) winner = w;
         end
      end
      if (winner >= 0) begin
         r  = m_tab[winner][0];
         f  = m_tab[winner][3];
         lo = int'(r[7:0]);
         if (f[3]) off = (((bank - lo) & 255) << 15) | int'(a[14:0]);
         else      off = (((bank - lo) & 255) << 16) | int'(a[15:0]);
         e_addr = 24'(int'(m_tab[winner][2]) | (off & int'(m_tab[winner][1])));
         e_hit  = 1;
         e_save = f[2];
         e_wr   = f[1] | (m_unlocked & !romsel);
         e_idx  = 3'(winner);
      end else begin
         e_addr = '0; e_hit = 0; e_save = 0; e_idx = '0;
         e_wr   = m_unlocked & !romsel;
      end
   endfunction

   function automatic void model_fsm(input bit stb, input logic [23:0] a, input bit unl);
      if (!m_unlocked) begin
         if (unl) m_unlocked = 1;
      end else if (!m_relocking) begin
         if (stb && a == RET) begin
            m_relocking = 1;
            m_left      = RCNT;
         end
      end else begin
         if (unl) begin
            m_relocking = 0;
         end else if (stb) begin
            m_left--;
            if (m_left == 0) begin
               m_relocking = 0;
               m_unlocked  = 0;
            end
         end
      end
   endfunction

   function automatic logic [23:0] exp_rdata();
`ifdef ADDR_MAP_HITCNT_EN
      return 24'(m_hits[cur_win]);
`else
      return 24'h0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input bit exp_valid);
      chk({tag, "/valid"},    24'(DEC_VALID),    24'(exp_valid));
      chk({tag, "/rom_addr"}, ROM_ADDR,          e_addr);
      chk({tag, "/rom_hit"},  24'(ROM_HIT),      24'(e_hit));
      chk({tag, "/saveram"},  24'(IS_SAVERAM),   24'(e_save));
      chk({tag, "/writable"}, 24'(IS_WRITABLE),  24'(e_wr));
      chk({tag, "/win_idx"},  24'(WIN_IDX),      24'(e_idx));
      chk({tag, "/unlocked"}, 24'(map_unlocked), 24'(m_unlocked));
      chk({tag, "/rdata"},    cfg_rdata,         exp_rdata());
   endtask

   // One clock of stimulus, entered and left at posedge+1.
   task automatic cycle(input string tag, input bit stb, input logic [23:0] a, input bit romsel,
                        input bit unl, input bit we, input int win, input int sel,
                        input logic [23:0] data);
      int winner;
      winner        = -1;
      cur_win       = win;
      SNES_ADDR_STB = stb;
      SNES_ADDR     = a;
      SNES_ROMSEL   = romsel;
      unlock_req    = unl;
      cfg_we        = we;
      cfg_win       = WW'(win);
      cfg_sel       = 2'(sel);
      cfg_wdata     = data;
      if (stb) model_decode(a, romsel, winner);
      @(posedge CLK);
      #1;
      SNES_ADDR_STB = 1'b0;
      unlock_req    = 1'b0;
      cfg_we        = 1'b0;
      if (winner >= 0 && m_hits[winner] < 65535) m_hits[winner]++;
      if (we) begin
         if (sel == 3) m_hits[win] = 0;
         m_tab[win][sel] = data;
      end
      model_fsm(stb, a, unl);
      chk_all(tag, stb);
      $display("[%0t] %-10s stb=%0b addr=%h rs=%0b unl=%0b we=%0b w=%0d s=%0d d=%h -> rom=%h hit=%0b sv=%0b wr=%0b idx=%0d ul=%0b rd=%h",
               $time, tag, stb, a, romsel, unl, we, win, sel, data,
               ROM_ADDR, ROM_HIT, IS_SAVERAM, IS_WRITABLE, WIN_IDX, map_unlocked, cfg_rdata);
   endtask

   task automatic strobe(input string tag, input logic [23:0] a, input bit romsel);
      cycle(tag, 1, a, romsel, 0, 0, cur_win, 0, 24'h0);
   endtask

   task automatic wr_cfg(input int win, input int sel, input logic [23:0] data);
      cycle("cfg", 0, 24'h0, 1, 0, 1, win, sel, data);
   endtask

   task automatic unlock();
      cycle("unlock", 0, 24'h0, 1, 1, 0, cur_win, 0, 24'h0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, lo, hi, sel, d;
      logic [23:0] a;

      SNES_ADDR = '0; SNES_ADDR_STB = 0; SNES_ROMSEL = 1; cfg_we = 0; cfg_win = '0;
      cfg_sel = '0; cfg_wdata = '0; unlock_req = 0; cur_win = 0;
      RST_N = 1'b1;
      model_reset();
      #2 RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK) RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk_all("reset", 0);

      // LoROM window over banks 00-3F, upper half only.
      wr_cfg(0, 0, 24'h023F00);
      wr_cfg(0, 1, 24'h3FFFFF);
      wr_cfg(0, 2, 24'h000000);
      wr_cfg(0, 3, 24'h000009);
      strobe("lorom", 24'h018123, 0);
      chk("lorom_const", ROM_ADDR, 24'h008123);
      cycle("idle", 0, 24'h0, 1, 0, 0, 0, 0, 24'h0);
      strobe("a15_low", 24'h010123, 0);

      // Overlapping windows on bank 70.
      wr_cfg(0, 0, 24'h007070);
      wr_cfg(1, 0, 24'h007070);
      wr_cfg(1, 1, 24'h001FFF);
      wr_cfg(1, 2, 24'hE00000);
      wr_cfg(1, 3, 24'h000005);
      strobe("prio", 24'h700010, 0);
      chk("prio_const", 24'(WIN_IDX), 24'h0);
      wr_cfg(0, 3, 24'h000000);
      strobe("save", 24'h700010, 0);
      chk("save_const", ROM_ADDR, 24'hE00010);
      // Write coinciding with a strobe: old table for this decode.
      cycle("coinc", 1, 24'h700010, 0, 0, 1, 1, 2, 24'hD00000);
      chk("coinc_const", ROM_ADDR, 24'hE00010);
      strobe("after", 24'h700010, 0);
      chk("after_const", ROM_ADDR, 24'hD00010);

      // Patch window and timed relock.
      unlock();
      strobe("patch", 24'hF01234, 1);
      chk("patch_const", ROM_ADDR, 24'hF01234);
      strobe("ret", RET, 1);
      for (int i = 0; i < RCNT; i++) strobe("relock", 24'h008000, 1);
      chk("relocked_const", 24'(map_unlocked), 24'h0);
      strobe("locked", 24'hF01234, 1);
      chk("locked_const", 24'(ROM_HIT), 24'h0);

      // Unlock during the relock grace period.
      unlock();
      strobe("ret2", RET, 0);
      for (int i = 0; i < 5; i++) strobe("grace", 24'h008000, 0);
      unlock();
      chk("reunlock_const", 24'(map_unlocked), 24'h1);
      strobe("ret3", RET, 0);
      for (int i = 0; i < RCNT; i++) strobe("relock2", 24'h700020, 0);

      // Random mix against the model.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 15) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
               lo = $urandom_range(0, 255);
               hi = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(lo, 255);
               d  = ($urandom_range(0, 3) << 16) | (hi << 8) | lo;
            end else if (sel == 3) begin
               d = $urandom_range(0, 15);
            end else begin
               d = ($urandom_range(0, 1) == 0) ? 'hFFFFFF : int'($urandom) & 'hFFFFFF;
            end
            wr_cfg($urandom_range(0, NW - 1), sel, 24'(d));
         end else if (r < 20) begin
            unlock();
         end else if (r < 25) begin
            cycle("idle", 0, 24'h0, 1, 0, 0, cur_win, 0, 24'h0);
         end else begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = RET;
            else if (r < 3)  a = {4'hF, 20'($urandom)};
            else             a = 24'($urandom);
            strobe("rand", a, 1'($urandom_range(0, 1)));
         end
      end

      // Reset in the middle of a burst.
      unlock();
      strobe("burst", 24'hF00000, 0);
      SNES_ADDR_STB = 1; SNES_ADDR = 24'hF00001;
      #2 RST_N = 1'b0;
      #1;
      model_reset();
      chk_all("async_rst", 0);
      SNES_ADDR_STB = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk_all("post_rst", 0);
      strobe("cleared", 24'h018123, 0);
      chk("cleared_const", 24'(ROM_HIT), 24'h0);

      // Hit counter saturation on window 2.
      wr_cfg(2, 0, 24'h00FF00);
      wr_cfg(2, 1, 24'hFFFFFF);
      wr_cfg(2, 3, 24'h000001);
      SNES_ADDR = 24'h018123; SNES_ROMSEL = 1; SNES_ADDR_STB = 1;
      repeat (70000) @(posedge CLK);
      #1;
      SNES_ADDR_STB = 0;
      m_hits[2] = 65535;
      $display("[%0t] burst      70000 strobes to 018123 on window 2", $time);
      strobe("sat", 24'h018123, 1);
`ifdef ADDR_MAP_HITCNT_EN
      chk("sat_const", cfg_rdata, 24'h00FFFF);
`endif
      wr_cfg(2, 3, 24'h000001);
      chk("clr_const", cfg_rdata, 24'h000000);
      strobe("count1", 24'h018123, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/addr_map_ctrl.md
# addr_map_ctrl

Parametrised, table-driven SNES address mapper for the cartridge FPGA. It generalises the fixed per-chip mapper decoders to NUM_WIN MCU-programmable windows with first-match priority, and registers the decode result one cycle after each SNES address strobe. It also adds a timed unlock/relock state machine, so the patch bank closes a programmable number of bus cycles after the SNES leaves the handler instead of dropping immediately. It sits between SNES bus capture and the SRAM arbiter, in place of a fixed-mapper decoder.

## Interface
Parameters:
- NUM_WIN, 4: number of mapping windows (1–8).
- RET_VEC, 24'h002A5A: address whose fetch marks handler exit.
- RELOCK_CNT, 16: address strobes to wait after handler exit before relocking (1–255).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- SNES_ADDR  in  24  SNES address, stable while SNES_ADDR_STB is high.
- SNES_ADDR_STB  in  1  one-CLK pulse per SNES bus cycle.
- SNES_ROMSEL  in  1  ROMSEL, active-low.
- cfg_we  in  1  table write strobe from the MCU.
- cfg_win  in  $clog2(NUM_WIN)  window index.
- cfg_sel  in  2  field select: 0 = range, 1 = mask, 2 = dest base, 3 = flags.
- cfg_wdata  in  24  field data.
- cfg_rdata  out  24  hit counter of cfg_win (see Configuration).
- unlock_req  in  1  pulse from the snescmd logic.
- ROM_ADDR  out  24  translated address.
- ROM_HIT  out  1  decoded address maps to SRAM.
- IS_SAVERAM  out  1  matched window is flagged as save RAM.
- IS_WRITABLE  out  1  writes are permitted.
- WIN_IDX  out  3  index of the matched window.
- DEC_VALID  out  1  one-cycle pulse when a new decode result is presented.
- map_unlocked  out  1  unlock FSM is not LOCKED.

## Operation
- Range field: [7:0] bank_lo, [15:8] bank_hi (inclusive), [17:16] a15 mode (00 = any, 01 = A15 must be 0, 10 = A15 must be 1, 11 = window never matches).
- Flags field: [0] enable, [1] writable, [2] saveram, [3] lorom. With lorom set, A15 is dropped from the offset.
- A window matches when it is enabled, bank_lo ≤ SNES_ADDR[23:16] ≤ bank_hi, and the a15 mode is satisfied. The lowest matching index wins.
- Offset:
  - lorom: {bank−bank_lo, A[14:0]}, where bank−bank_lo is 8 bits and the result is 23 bits zero-extended.
  - otherwise: {bank−bank_lo, A[15:0]}.
  - ROM_ADDR = dest | (offset & mask), truncated to 24 bits.
- Patch window: applies when the FSM is not LOCKED and SNES_ADDR[23:20] = 4'hF. It overrides the table: ROM_ADDR = SNES_ADDR, ROM_HIT = 1, IS_WRITABLE = 1, IS_SAVERAM = 0, WIN_IDX = 0.
- IS_WRITABLE = (writable flag & match) | patch | (not LOCKED & ~SNES_ROMSEL).
- On a miss: ROM_HIT = 0, ROM_ADDR = 0, WIN_IDX = 0, IS_SAVERAM = 0. IS_WRITABLE follows the ROMSEL term only.
- Unlock FSM:
  - LOCKED → UNLOCKED on unlock_req.
  - UNLOCKED → RELOCK on a strobe with SNES_ADDR = RET_VEC. The relock counter loads RELOCK_CNT.
  - In RELOCK, each strobe decrements the counter. At the strobe where the counter reaches 0, the FSM goes to LOCKED.
  - unlock_req in RELOCK returns the FSM to UNLOCKED.
  - unlock_req in UNLOCKED is ignored.

## Timing
- Decode latency is one CLK. A strobe in cycle n gives registered outputs and DEC_VALID in cycle n+1. Outputs hold until the next decode.
- Back-to-back strobes are supported at full rate.
- A table write that coincides with a strobe: the decode uses the old table, and the write is visible from cycle n+1.
- The decode uses the FSM state before that cycle's transition. The strobe that fetches RET_VEC still decodes as unlocked.
- map_unlocked is registered and reflects the new state in cycle n+1.
- Reset state:
  - All windows disabled; all fields and counters 0.
  - FSM LOCKED.
  - All outputs 0.
- Reset asserted mid-operation forces this state immediately (asynchronous assertion, synchronous release).

## Configuration
- ADDR_MAP_HITCNT_EN defined:
  - Each window has a 16-bit saturating hit counter, incremented on each decode where it is the winning window. Patch decodes are not counted.
  - cfg_rdata returns the counter of cfg_win.
  - A cfg_we with cfg_sel = 3 also clears that window's counter.
- ADDR_MAP_HITCNT_EN undefined: no counters are built, and cfg_rdata is tied to 0.

## Structure
- Package addr_map_pkg holds:
  - cfg_sel encodings and flag bit positions.
  - The a15 mode encodings.
  - The FSM state enum (LOCKED, UNLOCKED, RELOCK).
  - The window record typedef (range, mask, dest, flags).
- Sub-module addr_map_win: combinational match and offset/translation for one window, instantiated NUM_WIN times. The top level does the priority encode, patch override, FSM, registers and counters.

## Test plan
- Window 0 = banks 00–3F, a15 mode 10, lorom, mask 3FFFFF, dest 0, enabled. Strobe 01:8123 → next cycle ROM_HIT = 1, ROM_ADDR = 008123, DEC_VALID pulse.
- Windows 0 and 1 overlapping on bank 70, window 1 saveram with dest E00000 and mask 1FFF. Strobe 70:0010 → WIN_IDX = 0. Disable window 0 and repeat → ROM_ADDR = E00010, IS_SAVERAM = 1.
- unlock_req, then strobe F0:1234 → ROM_ADDR = F01234, IS_WRITABLE = 1. Strobe 002A5A, then 16 more strobes → map_unlocked falls after the 16th. A 17th strobe to F0:1234 with no window covering bank F0 → ROM_HIT = 0.
- In RELOCK after 5 strobes, pulse unlock_req → FSM UNLOCKED, and the counter reloads on the next RET_VEC fetch.
- Assert RST_N low mid-burst → all outputs 0 asynchronously. After release, strobe 01:8123 → ROM_HIT = 0, since the table is cleared.
- With ADDR_MAP_HITCNT_EN: 70000 strobes hitting window 2 → cfg_rdata = FFFF. A cfg_sel = 3 write to window 2 → cfg_rdata = 0.
